// File: rtl/pcpi_link_pkg.sv
// Shared definitions for the nibble-serial pin link: FSM states and nibble sizing,
// used by both the result transmitter and the instruction-nibble receiver.
package pcpi_link_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      PRESENT,
      RELEASE
   } link_state_e;

   localparam int NIB_W_DEF = 4;

   function automatic int num_nibs(input int data_w, input int nib_w);
      return data_w / nib_w;
   endfunction

   // A one-nibble word still needs a 1-bit counter to keep the port legal.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchronizer for a single asynchronous level from the pins;
// resets to 0 so the link FSMs see an idle host after reset.
module link_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stages;

   always_ff @(posedge clk) begin
      if (rst) begin
         stages <= '0;
      end else begin
         stages <= {stages[STAGES-2:0], d};
      end
   end

   assign q = stages[STAGES-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Captures the PCPI write-back result and shifts it out LSB nibble first over a
// four-phase valid/ack handshake with the off-chip host.
module pcpi_result_nibble_tx
   import pcpi_link_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NIB_W       = NIB_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pcpi_ready,
   input  logic              pcpi_wr,
   input  logic [DATA_W-1:0] pcpi_rd,
   input  logic              tx_ack,
   output logic [NIB_W-1:0]  tx_nibble,
   output logic              tx_valid,
   output logic              tx_last,
   output logic              tx_busy,
   output logic              tx_overflow
);

   localparam int NUM_NIBS = num_nibs(DATA_W, NIB_W);
   localparam int CNT_W    = cnt_w(NUM_NIBS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIBS - 1);

   link_state_e state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [NUM_NIBS-1:0][NIB_W-1:0] data_buf;
   logic ack_s;
   logic result_req;
   logic capture;
   logic load_nib;

   link_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (tx_ack),
      .q   (ack_s)
   );

   assign result_req = pcpi_ready && pcpi_wr;
   assign capture    = result_req && (state == IDLE);
   assign tx_busy    = (state != IDLE);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      state_next = state;
      count_next = count;
      load_nib   = 1'b0;
      unique case (state)
         IDLE: begin
            if (capture) begin
               state_next = ARM;
               count_next = '0;
            end
         end
         ARM: begin
            // Host must be seen idle before the first nibble, even if ack was stuck high.
            if (!ack_s) begin
               state_next = PRESENT;
               load_nib   = 1'b1;
            end
         end
         PRESENT: begin
            if (ack_s) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack_s) begin
               if (count == LAST_IDX) begin
                  state_next = IDLE;
               end else begin
                  state_next = PRESENT;
                  count_next = count + 1'b1;
                  load_nib   = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         data_buf    <= '0;
         tx_nibble   <= '0;
         tx_valid    <= 1'b0;
         tx_last     <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         state    <= state_next;
         count    <= count_next;
         tx_valid <= (state_next == PRESENT);
         if (capture) begin
            data_buf <= pcpi_rd;
         end
         // Nibble and last flag only move on entry to PRESENT, i.e. while tx_valid is low.
         if (load_nib) begin
            tx_nibble <= data_buf[count_next];
            tx_last   <= (count_next == LAST_IDX);
         end
         if (result_req && (state != IDLE)) begin
            tx_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Self-checking bench: a host model acks each nibble, and received nibbles are
// reassembled LSB-first and compared against the word handed to the transmitter.
module tb_pcpi_result_nibble_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcpi_ready;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        tx_ack;
   logic [3:0]  tx_nibble;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_busy;
   logic        tx_overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int stable_err;
   logic [3:0] got_nib[$];
   logic       got_last[$];

   always #5 clk = ~clk;

   pcpi_result_nibble_tx #(
      .DATA_W      (32),
      .NIB_W       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pcpi_ready  (pcpi_ready),
      .pcpi_wr     (pcpi_wr),
      .pcpi_rd     (pcpi_rd),
      .tx_ack      (tx_ack),
      .tx_nibble   (tx_nibble),
      .tx_valid    (tx_valid),
      .tx_last     (tx_last),
      .tx_busy     (tx_busy),
      .tx_overflow (tx_overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [31:0] w, input logic wr);
      pcpi_ready = 1'b1;
      pcpi_wr    = wr;
      pcpi_rd    = w;
      tick();
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = $urandom;
   endtask

   task automatic clear_got();
      got_nib.delete();
      got_last.delete();
      stable_err = 0;
   endtask

   // Host model: wait for valid, record, ack after a delay, wait for valid low, release ack.
   task automatic host_collect(input int n, input int dly);
      int w;
      int d;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (tx_valid !== 1'b1 && w < 200) begin
            tick();
            w++;
         end
         if (tx_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_timeout: nibble %0d got tx_valid=%b, required 1", i, tx_valid);
            return;
         end
         got_nib.push_back(tx_nibble);
         got_last.push_back(tx_last);
         d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
         repeat (d) begin
            tick();
            if (tx_nibble !== got_nib[$] || tx_valid !== 1'b1) stable_err++;
         end
         tx_ack = 1'b1;
         w = 0;
         while (tx_valid !== 1'b0 && w < 200) begin
            tick();
            if (tx_valid === 1'b1 && tx_nibble !== got_nib[$]) stable_err++;
            w++;
         end
         if (tx_valid !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL release_timeout: nibble %0d got tx_valid=%b, required 0", i, tx_valid);
            tx_ack = 1'b0;
            return;
         end
         d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
         repeat (d) tick();
         tx_ack = 1'b0;
      end
   endtask

   function automatic logic [31:0] got_word();
      logic [31:0] r = '0;
      for (int i = 0; i < got_nib.size() && i < 8; i++) r |= 32'(got_nib[i]) << (4 * i);
      return r;
   endfunction

   function automatic logic [7:0] got_last_mask();
      logic [7:0] r = '0;
      for (int i = 0; i < got_last.size() && i < 8; i++) r[i] = got_last[i];
      return r;
   endfunction

   task automatic check_word(input string name, input logic [31:0] exp);
      n_tests++;
      if (got_nib.size() !== 8) begin
         n_fail++;
         $display("FAIL %s_count: got %0d nibbles, required 8", name, got_nib.size());
      end
      n_tests++;
      if (got_word() !== exp) begin
         n_fail++;
         $display("FAIL %s_data: got %h, required %h", name, got_word(), exp);
      end
      n_tests++;
      if (got_last_mask() !== 8'h80) begin
         n_fail++;
         $display("FAIL %s_last: got mask %b, required 10000000", name, got_last_mask());
      end
      n_tests++;
      if (stable_err !== 0) begin
         n_fail++;
         $display("FAIL %s_stable: got %0d changes while valid, required 0", name, stable_err);
      end
   endtask

   task automatic wait_idle(input string name);
      int w = 0;
      while (tx_busy !== 1'b0 && w < 12) begin
         tick();
         w++;
      end
      n_tests++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle: got tx_busy=%b, required 0", name, tx_busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_tests++;
      if ({tx_valid, tx_busy, tx_last, tx_overflow, tx_nibble} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required 00000000",
                  {tx_valid, tx_busy, tx_last, tx_overflow, tx_nibble});
      end
      rst = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({tx_valid, tx_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release: got valid/busy %b, required 00", {tx_valid, tx_busy});
      end
   endtask

   task automatic test_reset_mid_present();
      int w = 0;
      int bad = 0;
      clear_got();
      capture(32'hCAFE_7531, 1'b1);
      host_collect(3, 2);
      while (tx_valid !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      n_tests++;
      if (tx_valid !== 1'b1 || tx_nibble !== 4'h7) begin
         n_fail++;
         $display("FAIL midrst_setup: got valid=%b nibble=%h, required 1 and 7", tx_valid, tx_nibble);
      end
      rst    = 1'b1;
      tx_ack = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({tx_valid, tx_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL midrst_abort: got valid/busy %b, required 00", {tx_valid, tx_busy});
      end
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) tx_ack = ~tx_ack;
         tick();
         if (tx_valid !== 1'b0 || tx_busy !== 1'b0) bad++;
      end
      tx_ack = 1'b0;
      repeat (4) tick();
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL midrst_quiet: got %0d active cycles, required 0", bad);
      end
   endtask

   task automatic test_single_word();
      clear_got();
      capture(32'h89AB_CDEF, 1'b1);
      n_tests++;
      if (tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy: got %b, required 1", tx_busy);
      end
      host_collect(8, 2);
      check_word("single", 32'h89AB_CDEF);
      wait_idle("single");
   endtask

   task automatic test_no_write();
      int bad = 0;
      pcpi_ready = 1'b1;
      pcpi_wr    = 1'b0;
      pcpi_rd    = 32'hFFFF_FFFF;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (tx_valid !== 1'b0 || tx_busy !== 1'b0 || tx_overflow !== 1'b0) bad++;
      end
      pcpi_ready = 1'b0;
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL nowrite_quiet: got %0d active cycles, required 0", bad);
      end
   endtask

   task automatic test_ack_stuck();
      int bad = 0;
      clear_got();
      tx_ack = 1'b1;
      repeat (5) tick();
      capture(32'h0000_0001, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_valid !== 1'b0 || tx_busy !== 1'b1) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL stuck_arm: got %0d bad cycles, required 0", bad);
      end
      tx_ack = 1'b0;
      tick();
      tick();
      n_tests++;
      if (tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_early: got tx_valid=%b, required 0", tx_valid);
      end
      tick();
      n_tests++;
      if (tx_valid !== 1'b1 || tx_nibble !== 4'h1) begin
         n_fail++;
         $display("FAIL stuck_first: got valid=%b nibble=%h, required 1 and 1", tx_valid, tx_nibble);
      end
      host_collect(8, 1);
      check_word("stuck", 32'h0000_0001);
      wait_idle("stuck");
   endtask

   task automatic test_overflow();
      int bad = 0;
      clear_got();
      capture(32'h1234_5678, 1'b1);
      repeat (3) tick();
      capture(32'h5555_5555, 1'b1);
      n_tests++;
      if (tx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_flag: got %b, required 1", tx_overflow);
      end
      host_collect(8, 2);
      check_word("ovf", 32'h1234_5678);
      wait_idle("ovf");
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_valid !== 1'b0 || tx_busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0 || tx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_dropped: got %0d active cycles, overflow=%b, required 0 and 1",
                  bad, tx_overflow);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (tx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b, required 0", tx_overflow);
      end
   endtask

   task automatic test_back_to_back();
      clear_got();
      capture(32'hA5C3_0F96, 1'b1);
      host_collect(8, 2);
      check_word("b2b_a", 32'hA5C3_0F96);
      wait_idle("b2b_a");
      clear_got();
      capture(32'h3C1E_D247, 1'b1);
      n_tests++;
      if (tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_capture: got busy=%b, required 1", tx_busy);
      end
      host_collect(8, 0);
      check_word("b2b_b", 32'h3C1E_D247);
      wait_idle("b2b_b");
   endtask

   task automatic test_random();
      logic [31:0] w;
      for (int k = 0; k < 6; k++) begin
         clear_got();
         w = $urandom;
         repeat ($urandom_range(0, 5)) tick();
         capture(w, 1'b1);
         host_collect(8, -1);
         check_word("rand", w);
         wait_idle("rand");
      end
   endtask

   initial begin
      rst        = 1'b1;
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = '0;
      tx_ack     = 1'b0;
      stable_err = 0;
      test_reset();
      test_reset_mid_present();
      test_single_word();
      test_no_write();
      test_ack_stuck();
      test_overflow();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
